// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: one single-ported sync-read memory shared by fetch (IF) and load/store (D).
// Ports: clk/rst; IF req/addr/gnt/rvalid/rdata; D req/we/be/addr/wdata/gnt/rvalid/rdata; mem_*; busy.
module unified_mem_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    O_NONE,
    O_IF,
    O_DLD,
    O_DST
  } owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic arb, force_if, d_win, if_win;

  // Word-aligned accesses: the byte offset bits are deliberately dropped.
  logic unused_lsbs;
  assign unused_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  // Arbitration is gated by rst so nothing is granted while in reset.
  assign arb      = rst && ((state_q == S_IDLE) || (state_q == S_RESP));
  assign force_if = if_req && (streak_q == SW'(MAX_STREAK));
  assign d_win    = arb && d_req && !force_if;
  assign if_win   = arb && if_req && !d_win;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'h0;
    mem_addr   = '0;
    mem_wdata  = '0;

    if (state_q == S_RESP) begin
      state_d = S_IDLE;
      owner_d = O_NONE;
    end

    if (state_q == S_WAIT) begin
      if (cnt_q == CW'(MEM_LAT - 1)) begin
        state_d = S_RESP;
        unique case (owner_q)
          O_IF:    if_rdata_d = mem_rdata;
          O_DLD:   d_rdata_d  = mem_rdata;
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    unique case (1'b1)
      d_win: begin
        d_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr[AW-1:2];
        mem_wdata = d_wdata;
        owner_d   = d_we ? O_DST : O_DLD;
        state_d   = S_WAIT;
        cnt_d     = '0;
        if (!if_req)
          streak_d = '0;
        else if (streak_q != SW'(MAX_STREAK))
          streak_d = streak_q + SW'(1);
      end
      if_win: begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_be   = 4'hF;
        mem_addr = if_addr[AW-1:2];
        owner_d  = O_IF;
        state_d  = S_WAIT;
        cnt_d    = '0;
        streak_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_q    <= O_NONE;
      cnt_q      <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_rvalid = (state_q == S_RESP) && (owner_q == O_IF);
  assign d_rvalid  = (state_q == S_RESP) &&
                     ((owner_q == O_DLD) || (owner_q == O_DST));
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q == S_WAIT);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: random IF/D traffic, scoreboard queues,
// transaction-level memory model and per-cycle grant expectations.
module tb_unified_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MEM_LAT = 1;
  localparam int MAX_STREAK = 4;
  localparam int NW = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  unified_mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        st;
    logic [31:0] data;
  } rsp_t;

  rsp_t        if_q[$];
  rsp_t        d_q[$];
  logic [31:0] env_mem [NW];
  logic [31:0] ref_mem [NW];
  logic [31:0] pipe [MEM_LAT];
  logic [31:0] if_hold, d_hold;
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int streak = 0;
  int next_arb = 0;
  int last_g = -10;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
      input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory environment: acts on the DUT's mem_* bus only.
  initial begin
    logic [31:0] pend;
    mem_rdata = '0;
    for (int k = 0; k < MEM_LAT; k++) pipe[k] = '0;
    forever begin
      @(negedge clk);
      pend = $urandom;
      if (mem_en) begin
        if (mem_we)
          env_mem[mem_addr] = merge(env_mem[mem_addr], mem_wdata, mem_be);
        else
          pend = env_mem[mem_addr];
      end
      @(posedge clk);
      #1;
      for (int k = MEM_LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = pend;
      mem_rdata = pipe[MEM_LAT-1];
    end
  end

  // Monitor: per-cycle expectations from the arbitration rules and
  // the transaction-level memory; responses checked from the queues.
  initial begin
    logic        allowed, ed, ei, eir, edr;
    logic [46:0] ebus;
    rsp_t        r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        chk("rst_ctrl", {if_gnt, d_gnt, if_rvalid, d_rvalid,
                         mem_en, mem_we, busy}, 0);
        chk("rst_bus", {mem_be, mem_addr, mem_wdata}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        if_q.delete();
        d_q.delete();
        if_hold = '0;
        d_hold = '0;
        streak = 0;
        next_arb = 0;
        last_g = -10;
      end else begin
        allowed = (cyc >= next_arb);
        ed = allowed && d_req && !(if_req && streak == MAX_STREAK);
        ei = allowed && !ed && if_req;
        chk("d_gnt", d_gnt, ed);
        chk("if_gnt", if_gnt, ei);
        chk("mem_en", mem_en, ed | ei);
        if (ed) ebus = {d_we, d_be, d_addr[AW-1:2], d_wdata};
        else if (ei) ebus = {1'b0, 4'hF, if_addr[AW-1:2], 32'h0};
        else ebus = '0;
        chk("mem_bus", {mem_we, mem_be, mem_addr, mem_wdata}, ebus);
        chk("busy", busy, (cyc > last_g) && (cyc < next_arb));
        eir = (if_q.size() > 0) && (if_q[0].due <= cyc);
        chk("if_rvalid", if_rvalid, eir);
        if (eir) begin
          r = if_q.pop_front();
          if_hold = r.data;
        end
        edr = (d_q.size() > 0) && (d_q[0].due <= cyc);
        chk("d_rvalid", d_rvalid, edr);
        if (edr) begin
          r = d_q.pop_front();
          if (!r.st) d_hold = r.data;
        end
        chk("if_rdata", if_rdata, if_hold);
        chk("d_rdata", d_rdata, d_hold);
        if (ed) begin
          r.due = cyc + MEM_LAT + 1;
          r.st = d_we;
          r.data = '0;
          if (d_we)
            ref_mem[d_addr[AW-1:2]] =
              merge(ref_mem[d_addr[AW-1:2]], d_wdata, d_be);
          else
            r.data = ref_mem[d_addr[AW-1:2]];
          d_q.push_back(r);
          if (!if_req) streak = 0;
          else if (streak < MAX_STREAK) streak++;
          next_arb = r.due;
          last_g = cyc;
        end
        if (ei) begin
          r.due = cyc + MEM_LAT + 1;
          r.st = 1'b0;
          r.data = ref_mem[if_addr[AW-1:2]];
          if_q.push_back(r);
          streak = 0;
          next_arb = r.due;
          last_g = cyc;
        end
      end
    end
  end

  task automatic if_txn(input logic [AW-1:0] a, output int n);
    if_req = 1'b1;
    if_addr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_gnt && n < 100);
    if (!if_gnt) begin
      checks++;
      $display("FAIL if_gnt_timeout: got no grant required grant");
    end
    tick();
    if_req = 1'b0;
  endtask

  task automatic d_txn(input logic we, input logic [3:0] be,
      input logic [AW-1:0] a, input logic [31:0] wd, output int n);
    d_req = 1'b1;
    d_we = we;
    d_be = be;
    d_addr = a;
    d_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_gnt && n < 100);
    if (!d_gnt) begin
      checks++;
      $display("FAIL d_gnt_timeout: got no grant required grant");
    end
    tick();
    d_req = 1'b0;
  endtask

  task automatic if_loop(input int cnt);
    int n;
    repeat (cnt) begin
      idle($urandom_range(0, 3));
      if_txn(AW'($urandom_range(0, 63)), n);
    end
  endtask

  task automatic d_loop(input int cnt);
    int n;
    repeat (cnt) begin
      idle($urandom_range(0, 1));
      d_txn(1'($urandom_range(0, 1)), 4'($urandom), AW'($urandom_range(0, 63)),
            $urandom, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_be = '0;
    d_addr = '0;
    d_wdata = '0;
    for (int k = 0; k < NW; k++) begin
      env_mem[k] = $urandom;
      ref_mem[k] = env_mem[k];
    end
    env_mem[4] = 32'h00500093;
    ref_mem[4] = 32'h00500093;
    idle(3);
    rst = 1'b1;
    idle(1);

    if_txn(12'h010, n);
    idle(3);
    chk("fetch_word", if_rdata, 32'h00500093);
    d_txn(1'b1, 4'b0011, 12'h024, 32'hDEADBEEF, n);
    idle(3);
    d_txn(1'b0, 4'hF, 12'h026, 32'h0, n);
    idle(3);

    fork
      if_txn(12'h100, n);
      d_txn(1'b0, 4'hF, 12'h200, 32'h0, n);
    join
    idle(3);

    if_req = 1'b1;
    if_addr = 12'h040;
    d_req = 1'b1;
    d_we = 1'b0;
    d_be = 4'hF;
    d_addr = 12'h044;
    idle(30);
    if_req = 1'b0;
    d_req = 1'b0;
    idle(4);

    fork
      if_loop(40);
      d_loop(60);
    join
    idle(5);

    d_txn(1'b0, 4'hF, 12'h008, 32'h0, n);
    if_req = 1'b1;
    if_addr = 12'h00C;
    rst = 1'b0;
    #1;
    chk("rst_async", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, busy}, 0);
    idle(2);
    rst = 1'b1;
    if_txn(12'h00C, n);
    chk("gnt_after_rst", n, 1);
    idle(4);

    fork
      if_loop(20);
      d_loop(30);
    join
    idle(6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
